slave_bus_arbiter: RTL and testbench

//  Downstream consumer of the slave bus shared by all bus_interface instances.

---
 rtl/slave_bus_arbiter_if.sv | 44 ++++
 rtl/slave_bus_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_slave_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_bus_arbiter_if.sv
// Slave bus + output byte stream bundle for slave_bus_arbiter.
//
// Slave bus side (shared by all bus_interface ports):
//   sl_arb_request  per-port frame-ready request
//   sl_arb_grant    one-hot grant from the arbiter
//   sl_latch_tail   one-cycle pulse: granted port retires its current frame
//   sl_addr         read offset within the granted frame
//   sl_data         granted port's entry at sl_addr, one cycle after sl_addr
//   sl_tail         granted port's frame length in entries
// Output stream side (valid/ready):
//   out_data, out_flag, out_last, out_src, out_valid, out_ready
//   frame_abort     one-cycle pulse: granted port dropped its request mid-frame
//
// Modport master is the arbiter; modport slave is the ports/downstream side.
interface slave_bus_arbiter_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned SRC_W     = 2
);
  logic [NUM_PORTS-1:0] sl_arb_request;
  logic [NUM_PORTS-1:0] sl_arb_grant;
  logic                 sl_latch_tail;
  logic [8:0]           sl_addr;
  logic [8:0]           sl_data;
  logic [8:0]           sl_tail;
  logic [7:0]           out_data;
  logic                 out_flag;
  logic                 out_last;
  logic [SRC_W-1:0]     out_src;
  logic                 out_valid;
  logic                 out_ready;
  logic                 frame_abort;

  modport master (
    input  sl_arb_request, sl_data, sl_tail, out_ready,
    output sl_arb_grant, sl_latch_tail, sl_addr,
    output out_data, out_flag, out_last, out_src, out_valid, frame_abort
  );

  modport slave (
    output sl_arb_request, sl_data, sl_tail, out_ready,
    input  sl_arb_grant, sl_latch_tail, sl_addr,
    input  out_data, out_flag, out_last, out_src, out_valid, frame_abort
  );
endinterface

// File: rtl/slave_bus_arbiter.sv
// slave_bus_arbiter
//
// Downstream consumer of the shared slave bus. Grants the bus to one requesting port at a
// time (round-robin), reads the granted port's frame by address from offset 0 to its tail,
// streams each entry out as a byte on a valid/ready port, then pulses sl_latch_tail so the
// port releases the frame. A port that drops its request before its frame is fully read
// gets a frame_abort pulse instead, and its frame is left in place.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave_bus_arbiter_if.master: slave bus (request/grant/latch/addr/data/tail),
//          output stream (out_data/flag/last/src/valid/ready) and frame_abort.
//
// All outputs are registered.
module slave_bus_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned SRC_W     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  slave_bus_arbiter_if.master bus
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StTail,
    StAddr,
    StData,
    StRelease
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                 latch_q, latch_d;
  logic                 abort_q, abort_d;
  logic [8:0]           addr_q, addr_d;
  logic [8:0]           rd_ptr_q, rd_ptr_d;
  logic [8:0]           len_q, len_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [IdxW-1:0]      win_q, win_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_flag_q, out_flag_d;
  logic                 out_last_q, out_last_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;
  logic                 out_valid_q, out_valid_d;

  // Round-robin pick: first set request searching upward from rr_q, with wrap.
  logic                 pick_found;
  logic [IdxW-1:0]      pick_idx;
  logic [IdxW-1:0]      cand_idx;
  int unsigned          cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand     = (32'(rr_q) + i) % NUM_PORTS;
      cand_idx = IdxW'(cand);
      if (!pick_found && bus.sl_arb_request[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  logic [NUM_PORTS-1:0] pick_onehot;
  logic                 req_granted;
  logic [IdxW-1:0]      rr_next;

  assign pick_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
  // The winner's request as seen through the held grant.
  assign req_granted = |(bus.sl_arb_request & grant_q);
  assign rr_next     = (win_q == IdxW'(NUM_PORTS - 1)) ? '0 : win_q + IdxW'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    latch_d     = 1'b0;
    abort_d     = 1'b0;
    addr_d      = addr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    rr_d        = rr_q;
    win_d       = win_q;
    out_data_d  = out_data_q;
    out_flag_d  = out_flag_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d   = pick_onehot;
          win_d     = pick_idx;
          out_src_d = SRC_W'(pick_idx);
          state_d   = StTail;
        end
      end

      StTail: begin
        if (!req_granted) begin
          abort_d = 1'b1;
          grant_d = '0;
          state_d = StIdle;
        end else begin
          len_d    = bus.sl_tail;
          rd_ptr_d = '0;
          if (bus.sl_tail == 9'd0) begin
            // Empty frame: nothing to stream, just retire it.
            latch_d = 1'b1;
            state_d = StRelease;
          end else begin
            addr_d  = '0;
            state_d = StAddr;
          end
        end
      end

      StAddr: begin
        if (!req_granted) begin
          abort_d = 1'b1;
          grant_d = '0;
          state_d = StIdle;
        end else begin
          state_d = StData;
        end
      end

      StData: begin
        // Request is not checked here: a presented byte always completes its handshake.
        if (!out_valid_q) begin
          out_data_d  = bus.sl_data[7:0];
          out_flag_d  = bus.sl_data[8];
          out_last_d  = (rd_ptr_q == len_q - 9'd1); // len_q is nonzero in this state
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            latch_d = 1'b1;
            state_d = StRelease;
          end else begin
            rd_ptr_d = rd_ptr_q + 9'd1;
            addr_d   = rd_ptr_q + 9'd1;
            state_d  = StAddr;
          end
        end
      end

      StRelease: begin
        // latch_q is high this cycle with the grant still held; drop both now.
        grant_d = '0;
        rr_d    = rr_next;
        state_d = StIdle;
      end

      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      latch_q     <= 1'b0;
      abort_q     <= 1'b0;
      addr_q      <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      rr_q        <= '0;
      win_q       <= '0;
      out_data_q  <= '0;
      out_flag_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      latch_q     <= latch_d;
      abort_q     <= abort_d;
      addr_q      <= addr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      out_data_q  <= out_data_d;
      out_flag_q  <= out_flag_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sl_arb_grant  = grant_q;
  assign bus.sl_latch_tail = latch_q;
  assign bus.sl_addr       = addr_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_flag      = out_flag_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_src       = out_src_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.frame_abort   = abort_q;

endmodule

// File: tb/tb_slave_bus_arbiter.sv
// Self-checking bench for slave_bus_arbiter. Ports are modelled as queues of frames; when a
// grant appears the reference model predicts the round-robin winner and pushes that frame's
// expected bytes into a scoreboard, which a separate monitor drains on each handshake.
module tb_slave_bus_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned SW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slave_bus_arbiter_if #(.NUM_PORTS(NP), .SRC_W(SW)) bus ();

  slave_bus_arbiter #(.NUM_PORTS(NP), .SRC_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0]    d;
    logic          f;
    logic          l;
    logic [SW-1:0] s;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] pdata[NP][$];
  int         plen [NP][$];
  bit         en   [NP];

  int rr_m, cur_port, ready_mode, abort_arm, abort_seen, latch_cnt, grant_cnt;
  bit abort_expect;
  int n_cmp, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  function automatic int rr_pick(input logic [NP-1:0] req, input int rr);
    for (int i = 0; i < NP; i++) begin
      if (req[(rr + i) % NP]) return (rr + i) % NP;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [NP-1:0] g);
    for (int i = 0; i < NP; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic [27:0] all_outs();
    return {bus.sl_arb_grant, bus.sl_latch_tail, bus.sl_addr, bus.out_data, bus.out_flag,
            bus.out_last, bus.out_src, bus.out_valid, bus.frame_abort};
  endfunction

  task automatic push_rand(input int p, input int len);
    for (int i = 0; i < len; i++) pdata[p].push_back(9'($urandom));
    plen[p].push_back(len);
  endtask

  // ---------------- port model + reference model (negedge) ----------------
  logic [NP-1:0] drv_g, prev_g, req_prev, req_now;
  logic [8:0]    prev_addr, v;
  int            prev_port, gp, w;
  exp_t          e;

  always @(negedge clk) begin
    drv_g = bus.sl_arb_grant;
    if (rst_n) begin
      check("grant_onehot", ($countones(drv_g) <= 1), 1'b1);
      if (drv_g != '0 && prev_g == '0) begin
        w = rr_pick(req_prev, rr_m);
        check("grant_winner", drv_g, (w < 0) ? 0 : (1 << w));
        cur_port = w;
        grant_cnt++;
        if (w >= 0 && plen[w].size() > 0) begin
          for (int i = 0; i < plen[w][0]; i++) begin
            v   = pdata[w][i];
            e.d = v[7:0];
            e.f = v[8];
            e.l = (i == plen[w][0] - 1);
            e.s = SW'(w);
            exp_q.push_back(e);
          end
        end
      end
      if (bus.sl_latch_tail) begin
        latch_cnt++;
        check("latch_grant", drv_g, (cur_port < 0) ? 0 : (1 << cur_port));
        check("latch_pending", exp_q.size(), 0);
        if (cur_port >= 0 && plen[cur_port].size() > 0) begin
          for (int i = 0; i < plen[cur_port][0]; i++) void'(pdata[cur_port].pop_front());
          void'(plen[cur_port].pop_front());
          rr_m = (cur_port + 1) % NP;
        end
      end
      if (bus.frame_abort) begin
        check("abort_expected", abort_expect, 1'b1);
        check("abort_grant", drv_g, 0);
        abort_seen++;
        abort_expect = 1'b0;
        exp_q.delete();
      end
    end
    prev_g = drv_g;

    // Registered port read: data answers the address seen one cycle earlier.
    if (prev_port >= 0 && plen[prev_port].size() > 0 && int'(prev_addr) < plen[prev_port][0])
      bus.sl_data = pdata[prev_port][prev_addr];
    else
      bus.sl_data = 9'($urandom);
    gp        = idx_of(drv_g);
    prev_addr = bus.sl_addr;
    prev_port = gp;
    if (gp >= 0 && plen[gp].size() > 0) bus.sl_tail = 9'(plen[gp][0]);
    else                                bus.sl_tail = 9'($urandom);

    // Drop the request during the address phase of the second byte.
    if (rst_n && abort_arm >= 0 && gp == abort_arm && bus.sl_addr == 9'd1) begin
      en[abort_arm] = 1'b0;
      abort_expect  = 1'b1;
      abort_arm     = -1;
    end

    for (int p = 0; p < NP; p++) req_now[p] = en[p] && (plen[p].size() > 0);
    bus.sl_arb_request = req_now;
    req_prev           = req_now;

    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom % 2);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  bit          stall_v;
  logic [21:0] stall_snap, snap;
  exp_t        got, want;

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      snap = {bus.sl_addr, bus.out_data, bus.out_flag, bus.out_last, bus.out_src, bus.out_valid};
      if (stall_v) check("stall_hold", snap, stall_snap);
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.out_data, bus.out_flag, bus.out_last, bus.out_src};
        if (exp_q.size() == 0) fail_now("byte_unexpected");
        else begin
          want = exp_q.pop_front();
          check("byte", got, want);
        end
      end
      stall_v    = bus.out_valid && !bus.out_ready;
      stall_snap = snap;
    end else begin
      stall_v = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_drain(input int budget, input string name);
    int  c;
    bit  busy;
    c = 0;
    busy = 1'b1;
    while (busy && c < budget) begin
      @(negedge clk);
      #3;
      c++;
      busy = (exp_q.size() != 0) || (bus.sl_arb_grant != '0);
      for (int p = 0; p < NP; p++) if (plen[p].size() != 0) busy = 1'b1;
    end
    if (busy) fail_now(name);
  endtask

  int lc, c;

  initial begin
    for (int p = 0; p < NP; p++) en[p] = 1'b1;
    rr_m = 0; cur_port = -1; prev_port = -1; abort_arm = -1; ready_mode = 0;
    abort_seen = 0; latch_cnt = 0; grant_cnt = 0; n_cmp = 0; n_fail = 0;
    prev_g = '0; req_prev = '0; prev_addr = '0; stall_v = 1'b0;
    bus.sl_arb_request = '0; bus.sl_data = '0; bus.sl_tail = '0; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1 check("reset_outputs", all_outs(), 0);
    @(posedge clk); #3 rst_n = 1'b1;

    // Single frame on port 1.
    @(posedge clk); #3;
    pdata[1].push_back(9'h0AA); pdata[1].push_back(9'h155); pdata[1].push_back(9'h033);
    plen[1].push_back(3);
    wait_drain(200, "drain_single");
    check("single_latches", latch_cnt, 1);

    // Round-robin among ports 0, 2, 3 with 1-byte frames.
    @(posedge clk); #3;
    for (int k = 0; k < 4; k++) begin
      push_rand(0, 1); push_rand(2, 1); push_rand(3, 1);
    end
    wait_drain(400, "drain_rr");
    check("rr_grants", grant_cnt, 13);

    // Backpressure: out_ready low for 5 cycles mid-frame.
    @(posedge clk); #3;
    push_rand(1, 5);
    c = 0;
    while (!(bus.out_valid && bus.sl_addr == 9'd2) && c < 100) begin @(negedge clk); c++; end
    if (!(bus.out_valid && bus.sl_addr == 9'd2)) fail_now("wait_bp");
    ready_mode = 2;
    repeat (5) @(negedge clk);
    #3 ready_mode = 0;
    wait_drain(200, "drain_bp");

    // Empty frame on port 2.
    lc = latch_cnt;
    @(posedge clk); #3 push_rand(2, 0);
    wait_drain(100, "drain_empty");
    check("empty_latch", latch_cnt, lc + 1);

    // Abort: port 3 drops its request during the address phase of byte 2.
    lc = latch_cnt;
    @(posedge clk); #3;
    abort_arm = 3;
    push_rand(3, 3);
    c = 0;
    while (abort_seen == 0 && c < 200) begin @(negedge clk); c++; end
    if (abort_seen == 0) fail_now("wait_abort");
    repeat (3) @(negedge clk);
    #3;
    check("abort_no_latch", latch_cnt, lc);
    check("abort_grant_clear", bus.sl_arb_grant, 0);
    // rr pointer must still favour port 3 over port 0.
    push_rand(0, 2);
    en[3] = 1'b1;
    wait_drain(300, "drain_abort");
    check("abort_refetch_latches", latch_cnt, lc + 2);

    // Randomised traffic with random backpressure.
    ready_mode = 1;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #3;
      for (int f = 0; f < 10; f++) push_rand(int'($urandom % NP), int'($urandom % 6));
      wait_drain(3000, "drain_random");
    end
    @(posedge clk); #3 push_rand(1, 300);
    wait_drain(6000, "drain_long");

    // Async reset while a byte is presented.
    ready_mode = 2;
    lc = latch_cnt;
    @(posedge clk); #3 push_rand(0, 4);
    c = 0;
    while (!bus.out_valid && c < 100) begin @(negedge clk); c++; end
    if (!bus.out_valid) fail_now("wait_valid_rst");
    #3 rst_n = 1'b0;
    #1 check("reset_async", all_outs(), 0);
    exp_q.delete();
    rr_m = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    ready_mode = 0;
    wait_drain(300, "drain_after_reset");
    check("reset_refetch_latch", latch_cnt, lc + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
